// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - multi-cycle unsigned shift-add multiply / restoring divide
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   start, op, a, b     request; op 00=MUL 01=MULHU 10=DIVU 11=REMU
//   flush               cancel current or requested operation
//   busy                high while iterating
//   stall               pipeline hold, busy | (start & ~busy)
//   done                one-cycle pulse, result valid
//   result              last completed result, held until next completion
//   div_by_zero         valid with done, DIVU/REMU had b == 0
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t             state;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] prod_q;   // {partial sum, remaining multiplier bits}
  logic [WIDTH-1:0]   rem_q;    // partial remainder, always < divisor
  logic [WIDTH-1:0]   quo_q;    // dividend bits shift out MSB first, quotient bits shift in
  logic [CW-1:0]      cnt_q;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_sub;
  logic               rem_ge;
  logic               rem_unused;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH-1:0]   fin_result;
  logic               zero_div;

  assign stall    = busy | (start & ~busy);
  assign zero_div = op[1] & (b == '0);

  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit is set, then shift the whole product right.
    mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
    prod_nx = {mul_sum, prod_q[WIDTH-1:1]};

    // Restoring divide: the shifted remainder needs one extra bit because it
    // can reach 2*divisor-1 before the trial subtraction.
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, b_q};
    rem_ge    = (rem_shift >= {1'b0, b_q});
    {rem_unused, rem_nx} = rem_ge ? rem_sub : rem_shift;
    quo_nx    = {quo_q[WIDTH-2:0], rem_ge};

    fin_result = '0;
    case (op_q)
      2'b00:   fin_result = prod_nx[WIDTH-1:0];
      2'b01:   fin_result = prod_nx[2*WIDTH-1:WIDTH];
      2'b10:   fin_result = quo_nx;
      default: fin_result = rem_nx;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      // Cancelled work never reports; result/div_by_zero keep old values.
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          prod_q <= prod_nx;
          rem_q  <= rem_nx;
          quo_q  <= quo_nx;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            result      <= fin_result;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          // IDLE and DONE both accept, which gives back-to-back issue.
          done <= 1'b0;
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            cnt_q  <= '0;
            prod_q <= {{WIDTH{1'b0}}, b};
            rem_q  <= '0;
            quo_q  <= a;
            if (zero_div) begin
              // Bypass iteration: DIVU gives all ones, REMU gives the dividend.
              state       <= S_DONE;
              done        <= 1'b1;
              result      <= op[0] ? a : '1;
              div_by_zero <= 1'b1;
            end else begin
              state <= S_RUN;
              busy  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle unsigned multiply/divide unit for the 16-bit pipelined processor. It accepts one operation from the execute stage and runs a shift-add multiply or a restoring divide, one bit per cycle. While it works it holds the pipeline through a `stall` output, then presents the result for exactly one `done` cycle. A flush input lets branch/hazard control cancel an in-flight operation.

## Interface
- `WIDTH`, default 16: operand and result width in bits; the iteration count equals `WIDTH`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a new operation; sampled on the rising edge.
- `op` input 2: operation select. 00 = MUL (low `WIDTH` bits of the product), 01 = MULHU (high `WIDTH` bits), 10 = DIVU (quotient), 11 = REMU (remainder).
- `a` input `WIDTH`: operand A (multiplicand or dividend), unsigned.
- `b` input `WIDTH`: operand B (multiplier or divisor), unsigned.
- `flush` input 1: cancel the current or requested operation.
- `busy` output 1: high while iterating (state RUN).
- `stall` output 1: combinational pipeline hold, equal to `busy | (start & ~busy)`.
- `done` output 1: one-cycle pulse when `result` is valid (state DONE).
- `result` output `WIDTH`: result of the last completed operation; held until the next completion.
- `div_by_zero` output 1: valid with `done`; high when DIVU or REMU had `b == 0`.

## Operation
- **Reset:** state becomes IDLE; `busy`, `done`, `div_by_zero` = 0; `result` = 0; all internal registers = 0.
- **States:**
  - IDLE: waiting for a request.
  - RUN: iterating; iteration counter runs 0..`WIDTH`-1.
  - DONE: result valid for one cycle.
- **Accept:** `start` is accepted on an edge when the state is IDLE or DONE and `flush` = 0.
  - `op`, `a`, `b` are latched at that edge.
  - The state goes to RUN and the counter is cleared.
- **Ignored requests:** `start` while in RUN is ignored; operands are not re-latched.
- **MUL/MULHU:** shift-add on a 2×`WIDTH` product register, one multiplier bit per RUN cycle. The product is exact modulo 2^(2·`WIDTH`).
- **DIVU/REMU:** restoring division on a `WIDTH`+1-bit partial remainder, one quotient bit per RUN cycle (MSB first).
- **Completion:** on the edge where the counter equals `WIDTH`-1, the state goes to DONE and `result` is loaded from the selected field.
- **Divide by zero:** DIVU/REMU with `b == 0` skips RUN and goes from accept directly to DONE.
  - DIVU result = all ones; REMU result = `a`.
  - `div_by_zero` = 1.
- **DONE exit:** DONE lasts one cycle. The state then goes to IDLE, or to RUN if a new `start` is accepted in that cycle (back-to-back requests).
- **Flush:** in any state, the next state is IDLE.
  - `done` is not asserted for the cancelled operation.
  - `result` and `div_by_zero` keep their previous values.
  - `start` in the same cycle as `flush` is dropped.
- **Priority:** `reset` > `flush` > `start`.

## Timing
- Accept edge E0 → RUN occupies the `WIDTH` cycles after E0 → `done` is high in cycle E0+`WIDTH`+1 (the cycle after edge E`WIDTH`).
- Latency from accept edge to `done` is 16 cycles at the default width.
- Divide-by-zero: `done` is high in the cycle right after E0 (latency 1).
- `stall`:
  - High from the cycle `start` is raised through the last RUN cycle.
  - Low in the DONE cycle, so the pipeline captures `result` on the edge that ends DONE.
- `busy` is high for exactly `WIDTH` cycles per non-bypassed operation.
- `result` changes only on the edge entering DONE.
- Reset or flush in mid-RUN takes effect on the next edge: `busy` = 0 and the state is IDLE in the following cycle.

## Test plan
- Reset, then MUL with a=0x1234, b=0x0010 → `busy` high for 16 cycles, then `done` for 1 cycle with `result`=0x2340 and `div_by_zero`=0. Repeat with MULHU on the same operands → `result`=0x0001.
- MULHU with a=0xFFFF, b=0xFFFF → `result`=0xFFFE. Immediately start MUL in the DONE cycle → accepted back-to-back; the next `done` comes 16 cycles later with `result`=0x0001.
- DIVU with a=100, b=7 → `result`=14. REMU on the same operands → `result`=2. Check `stall` is low only in the DONE cycle.
- DIVU with a=0x1234, b=0 → `done` one cycle after the accept edge with `result`=0xFFFF and `div_by_zero`=1. REMU with a=0x1234, b=0 → `result`=0x1234.
- Start DIVU 100/7, assert `flush` in RUN cycle 5 → IDLE next cycle, no `done`, `result` still equals the prior value. Pulse `start` with new operands during RUN → ignored and the original completes with its own result.
- Assert `reset` mid-RUN → next cycle all outputs are 0 and the state is IDLE. Then MUL 3×5 → `result`=15 after 16 cycles.
